// File: rtl/wavetable_loader_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wavetable_loader_if : sample stream in, RAM write port out           |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface wavetable_loader_if #(
  parameter int DATAWIDTH = 16,
  parameter int ADDRWIDTH = 8,
  parameter int BANKWIDTH = 2
);
  logic                 start;
  logic                 abort;
  logic [BANKWIDTH-1:0] bank_sel;
  logic [BANKWIDTH-1:0] rbank_active;
  logic [DATAWIDTH-1:0] din;
  logic                 din_valid;
  logic                 din_ready;
  logic [ADDRWIDTH-1:0] WADDR;
  logic [BANKWIDTH-1:0] WBANK;
  logic [DATAWIDTH-1:0] WDATA;
  logic                 WE;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output start, abort, bank_sel, rbank_active, din, din_valid,
    input  din_ready, WADDR, WBANK, WDATA, WE, busy, done, err
  );

  modport slave (
    input  start, abort, bank_sel, rbank_active, din, din_valid,
    output din_ready, WADDR, WBANK, WDATA, WE, busy, done, err
  );
endinterface
`default_nettype wire

// File: rtl/wavetable_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wavetable_loader : writes one full table into a RAM bank, never the  |
// | bank the oscillator is reading.                      Rev 1.0         |
// +----------------------------------------------------------------------+
module wavetable_loader #(
  parameter int DATAWIDTH = 16,
  parameter int ADDRWIDTH = 8,
  parameter int BANKWIDTH = 2
) (
  input  wire logic         clk,
  input  wire logic         rst,
  wavetable_loader_if.slave s_bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_BANK = 3'd1,
    S_LOAD      = 3'd2,
    S_FLUSH     = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam logic [ADDRWIDTH-1:0] c_LAST = {ADDRWIDTH{1'b1}};

  state_t               r_state;
  logic [BANKWIDTH-1:0] r_tgt;
  logic [ADDRWIDTH-1:0] r_cnt;
  logic [ADDRWIDTH-1:0] r_waddr;
  logic [BANKWIDTH-1:0] r_wbank;
  logic [DATAWIDTH-1:0] r_wdata;
  logic                 r_we;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_err;

  logic w_bank_free;
  logic w_din_ready;
  logic w_xfer;

  // Ready is combinational so a read-bank collision stalls the same cycle.
  assign w_bank_free = (r_tgt != s_bus.rbank_active);
  assign w_din_ready = (r_state == S_LOAD) && w_bank_free && !s_bus.abort;
  assign w_xfer      = w_din_ready && s_bus.din_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_tgt   <= '0;
      r_cnt   <= '0;
      r_waddr <= '0;
      r_wbank <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_we   <= 1'b0;
      r_done <= 1'b0;
      r_err  <= s_bus.start && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (s_bus.start) begin
            r_tgt   <= s_bus.bank_sel;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= (s_bus.bank_sel == s_bus.rbank_active) ? S_WAIT_BANK : S_LOAD;
          end
        end
        S_WAIT_BANK: begin
          if (s_bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_bank_free) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (s_bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (w_xfer) begin
            r_waddr <= r_cnt;
            r_wbank <= r_tgt;
            r_wdata <= s_bus.din;
            r_we    <= 1'b1;
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == c_LAST) begin
              r_state <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          // The last word's strobe is already on the bus during this cycle.
          if (s_bus.abort) begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign s_bus.din_ready = w_din_ready;
  assign s_bus.WADDR     = r_waddr;
  assign s_bus.WBANK     = r_wbank;
  assign s_bus.WDATA     = r_wdata;
  assign s_bus.WE        = r_we;
  assign s_bus.busy      = r_busy;
  assign s_bus.done      = r_done;
  assign s_bus.err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_wavetable_loader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wavetable_loader : directed self-checking bench for the loader    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_wavetable_loader;

  localparam int c_DW = 16;
  localparam int c_AW = 8;
  localparam int c_BW = 2;

  logic clk;
  logic rst;

  wavetable_loader_if #(.DATAWIDTH(c_DW), .ADDRWIDTH(c_AW), .BANKWIDTH(c_BW)) bus ();

  wavetable_loader #(.DATAWIDTH(c_DW), .ADDRWIDTH(c_AW), .BANKWIDTH(c_BW)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .s_bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [c_AW-1:0] q_addr[$];
  logic [c_BW-1:0] q_bank[$];
  logic [c_DW-1:0] q_data[$];
  int              n_done = 0;

  always @(negedge clk) begin
    if (bus.WE) begin
      q_addr.push_back(bus.WADDR);
      q_bank.push_back(bus.WBANK);
      q_data.push_back(bus.WDATA);
    end
    if (bus.done) n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clear_log();
    q_addr.delete();
    q_bank.delete();
    q_data.delete();
    n_done = 0;
  endtask

  // Called at a negedge; returns at the negedge after the start cycle.
  task automatic do_start(input logic [c_BW-1:0] bank, input logic [c_BW-1:0] rb);
    bus.rbank_active = rb;
    bus.bank_sel     = bank;
    bus.din_valid    = 1'b0;
    bus.start        = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_busy", {31'd0, bus.busy}, 32'd1);
  endtask

  // Drives din = k+3 for word k until done (or the abort cycle); checks
  // one-cycle write latency, sequential addresses, stall and err behaviour.
  task automatic feed(input logic [c_BW-1:0] tgt, input logic [c_BW-1:0] rb,
                      input bit toggle, input int stall_at, input int stall_len,
                      input int abort_at, input int err_at);
    int k, st, cyc, last_x;
    bit v, xfer, stalled, abrt, st_now, st_prev, err_sent, fin;
    k = 0; st = 0; cyc = 0; last_x = -100;
    v = 1'b1; st_prev = 1'b0; err_sent = 1'b0; fin = 1'b0;
    while (!fin && cyc < 2000) begin
      stalled = (stall_at >= 0) && (k == stall_at) && (st < stall_len);
      abrt    = (abort_at >= 0) && (k == abort_at);
      st_now  = (err_at >= 0) && (k == err_at) && !err_sent;
      if (st_now) err_sent = 1'b1;
      bus.rbank_active = stalled ? tgt : rb;
      bus.din          = c_DW'(k + 3);
      bus.din_valid    = toggle ? v : 1'b1;
      bus.abort        = abrt;
      bus.start        = st_now;
      bus.bank_sel     = ~tgt;
      #1;
      xfer = bus.din_valid && bus.din_ready;
      if (stalled) chk("stall_rdy", {31'd0, bus.din_ready}, 32'd0);
      if (abrt)    chk("abort_rdy", {31'd0, bus.din_ready}, 32'd0);
      @(negedge clk);
      cyc++;
      chk("we_lat", {31'd0, bus.WE}, {31'd0, xfer});
      if (xfer) begin
        chk("waddr", {24'd0, bus.WADDR}, 32'(k & 255));
        last_x = cyc - 1;
        k++;
      end
      if (stalled) begin
        chk("stall_we", {31'd0, bus.WE}, 32'd0);
        st++;
      end
      if (st_now)       chk("err_pulse", {31'd0, bus.err}, 32'd1);
      else if (st_prev) chk("err_clear", {31'd0, bus.err}, 32'd0);
      st_prev   = st_now;
      v         = ~v;
      bus.start = 1'b0;
      bus.abort = 1'b0;
      if (abrt) begin
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        fin = 1'b1;
      end else if (bus.done) begin
        chk("done_lat", 32'(cyc - last_x), 32'd2);
        chk("done_busy", {31'd0, bus.busy}, 32'd1);
        fin = 1'b1;
      end
    end
    chk("feed_end", {31'd0, fin}, 32'd1);
    bus.din_valid    = 1'b0;
    bus.rbank_active = rb;
  endtask

  // Called at the negedge where done was seen: done must be a single pulse.
  task automatic check_table(input logic [c_BW-1:0] tgt);
    int bad;
    @(negedge clk);
    #1;
    chk("done_once", {31'd0, bus.done}, 32'd0);
    chk("busy_fall", {31'd0, bus.busy}, 32'd0);
    bad = 0;
    foreach (q_addr[i]) begin
      if (q_addr[i] !== c_AW'(i) || q_bank[i] !== tgt || q_data[i] !== c_DW'(i + 3)) bad++;
    end
    chk("we_count", 32'(q_addr.size()), 32'd256);
    chk("we_seq", 32'(bad), 32'd0);
    chk("done_count", 32'(n_done), 32'd1);
  endtask

  initial begin
    rst              = 1'b1;
    bus.start        = 1'b0;
    bus.abort        = 1'b0;
    bus.bank_sel     = '0;
    bus.rbank_active = '0;
    bus.din          = '0;
    bus.din_valid    = 1'b0;
    #12;
    chk("rst_we",    {31'd0, bus.WE},        32'd0);
    chk("rst_busy",  {31'd0, bus.busy},      32'd0);
    chk("rst_ready", {31'd0, bus.din_ready}, 32'd0);
    chk("rst_flags", {30'd0, bus.done, bus.err}, 32'd0);
    chk("rst_bus",   {6'd0, bus.WBANK, bus.WADDR, bus.WDATA}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Clean load into bank 1
    clear_log();
    do_start(2'd1, 2'd0);
    feed(2'd1, 2'd0, 1'b0, -1, 0, -1, -1);
    check_table(2'd1);

    // Conflict at start: wait until the oscillator leaves bank 2
    clear_log();
    do_start(2'd2, 2'd2);
    bus.din_valid = 1'b1;
    repeat (4) begin
      #1;
      chk("wait_rdy", {31'd0, bus.din_ready}, 32'd0);
      @(negedge clk);
      chk("wait_we", {31'd0, bus.WE}, 32'd0);
      chk("wait_busy", {31'd0, bus.busy}, 32'd1);
    end
    bus.din_valid    = 1'b0;
    bus.rbank_active = 2'd0;
    #1;
    chk("wait_rdy_same", {31'd0, bus.din_ready}, 32'd0);
    @(negedge clk);
    #1;
    chk("wait_rdy_next", {31'd0, bus.din_ready}, 32'd1);
    feed(2'd2, 2'd0, 1'b0, -1, 0, -1, -1);
    check_table(2'd2);

    // Mid-load stall after 100 words
    clear_log();
    do_start(2'd3, 2'd0);
    feed(2'd3, 2'd0, 1'b0, 100, 10, -1, -1);
    check_table(2'd3);

    // Backpressure with alternating valid
    clear_log();
    do_start(2'd1, 2'd2);
    feed(2'd1, 2'd2, 1'b1, -1, 0, -1, -1);
    check_table(2'd1);

    // start while busy pulses err without disturbing the load
    clear_log();
    do_start(2'd0, 2'd1);
    feed(2'd0, 2'd1, 1'b0, -1, 0, -1, 30);
    check_table(2'd0);

    // Abort after 50 words, with a coincident start
    clear_log();
    do_start(2'd2, 2'd3);
    feed(2'd2, 2'd3, 1'b0, -1, 0, 50, 50);
    @(negedge clk);
    #1;
    chk("abort_we_after", {31'd0, bus.WE}, 32'd0);
    chk("abort_cnt", 32'(q_addr.size()), 32'd50);
    chk("abort_last", (q_addr.size() > 0) ? {24'd0, q_addr[q_addr.size()-1]} : 32'hFFFF, 32'h31);
    chk("abort_ndone", 32'(n_done), 32'd0);
    clear_log();
    do_start(2'd2, 2'd3);
    feed(2'd2, 2'd3, 1'b0, -1, 0, -1, -1);
    check_table(2'd2);

    // Asynchronous reset in the middle of a load
    clear_log();
    do_start(2'd1, 2'd0);
    bus.din_valid = 1'b1;
    bus.din       = 16'hABCD;
    repeat (20) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_we",    {31'd0, bus.WE},        32'd0);
    chk("arst_busy",  {31'd0, bus.busy},      32'd0);
    chk("arst_ready", {31'd0, bus.din_ready}, 32'd0);
    chk("arst_bus",   {6'd0, bus.WBANK, bus.WADDR, bus.WDATA}, 32'd0);
    @(negedge clk);
    rst           = 1'b0;
    bus.din_valid = 1'b0;
    @(negedge clk);
    chk("arst_idle", {31'd0, bus.busy}, 32'd0);
    clear_log();
    do_start(2'd1, 2'd0);
    feed(2'd1, 2'd0, 1'b0, -1, 0, -1, -1);
    check_table(2'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
